// File: rtl/reg_ctrl.sv
// reg_ctrl: byte-stream command sequencer and sole master of the register file.
// It turns write frames {CMD_WR, addr, data} and read frames {CMD_RD, addr} into
// regFile pulses. Read results go to the transmitter on a valid/ready handshake.
//
//   state     | meaning
//   ----------+--------------------------------------------------------------
//   S_IDLE    | waiting for a command byte; any other byte raises cmd_err
//   S_WR_ADDR | write frame, waiting for the address byte
//   S_WR_DATA | write frame, waiting for the data byte
//   S_RD_ADDR | read frame, waiting for the address byte
//   S_RD_WAIT | rdEn issued, waiting for rdData_vld, bounded by RD_TIMEOUT
//   S_TX_HOLD | read byte presented on tx, waiting for tx_ready
module reg_ctrl #(
    parameter int                DATA_W     = 8,
    parameter int                ADDR_W     = 4,
    parameter logic [DATA_W-1:0] CMD_WR     = 8'hAA,
    parameter logic [DATA_W-1:0] CMD_RD     = 8'hBB,
    parameter int                RD_TIMEOUT = 4
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [DATA_W-1:0] rx_data_i,
    input  logic              rx_valid_i,
    output logic [ADDR_W-1:0] rf_addr_o,
    output logic [DATA_W-1:0] rf_wrData_o,
    output logic              rf_wrEn_o,
    output logic              rf_rdEn_o,
    input  logic [DATA_W-1:0] rf_rdData_i,
    input  logic              rf_rdData_vld_i,
    output logic [DATA_W-1:0] tx_data_o,
    output logic              tx_valid_o,
    input  logic              tx_ready_i,
    output logic              busy_o,
    output logic              cmd_err_o
);

    localparam int TMR_W = $clog2(RD_TIMEOUT + 1);
    // The timer is loaded in the rdEn cycle and counts the remaining cycles in
    // which rdData_vld is still accepted, so the whole window is RD_TIMEOUT cycles.
    localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(RD_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WR_ADDR = 3'd1,
        S_WR_DATA = 3'd2,
        S_RD_ADDR = 3'd3,
        S_RD_WAIT = 3'd4,
        S_TX_HOLD = 3'd5
    } state_t;

    state_t            state_q, state_d;

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [TMR_W-1:0]  timer_q, timer_d;

    logic [ADDR_W-1:0] rf_addr_q, rf_addr_d;
    logic [DATA_W-1:0] rf_wrData_q, rf_wrData_d;
    logic              rf_wrEn_q, rf_wrEn_d;
    logic              rf_rdEn_q, rf_rdEn_d;
    logic [DATA_W-1:0] tx_data_q, tx_data_d;
    logic              tx_valid_q, tx_valid_d;
    logic              busy_q, busy_d;
    logic              cmd_err_q, cmd_err_d;

    logic              addr_ok;
    logic              is_cmd;
    logic              tmr_done;
    logic              tx_accept;

    // Address bytes must fit the register file; upper bits set means a bad address.
    assign addr_ok   = (rx_data_i[DATA_W-1:ADDR_W] == '0);
    assign is_cmd    = (rx_data_i == CMD_WR) || (rx_data_i == CMD_RD);
    assign tmr_done  = (timer_q == '0);
    assign tx_accept = tx_valid_q && tx_ready_i;

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode: frame parsing, read wait and tx handshake
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (rx_valid_i) begin
                    if (rx_data_i == CMD_WR) begin
                        state_d = S_WR_ADDR;
                    end else if (rx_data_i == CMD_RD) begin
                        state_d = S_RD_ADDR;
                    end
                end
            end
            S_WR_ADDR: begin
                if (rx_valid_i) begin
                    state_d = addr_ok ? S_WR_DATA : S_IDLE;
                end
            end
            S_WR_DATA: begin
                if (rx_valid_i) begin
                    state_d = S_IDLE;
                end
            end
            S_RD_ADDR: begin
                if (rx_valid_i) begin
                    state_d = addr_ok ? S_RD_WAIT : S_IDLE;
                end
            end
            S_RD_WAIT: begin
                if (rf_rdData_vld_i) begin
                    state_d = S_TX_HOLD;
                end else if (tmr_done) begin
                    state_d = S_IDLE;
                end
            end
            S_TX_HOLD: begin
                if (tx_accept) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output and datapath next values; pulses default low, everything else holds
    always_comb begin
        addr_d      = addr_q;
        timer_d     = timer_q;
        rf_addr_d   = rf_addr_q;
        rf_wrData_d = rf_wrData_q;
        rf_wrEn_d   = 1'b0;
        rf_rdEn_d   = 1'b0;
        tx_data_d   = tx_data_q;
        tx_valid_d  = tx_valid_q;
        cmd_err_d   = 1'b0;
        busy_d      = (state_d != S_IDLE);
        case (state_q)
            S_IDLE: begin
                if (rx_valid_i && !is_cmd) begin
                    cmd_err_d = 1'b1;
                end
            end
            S_WR_ADDR: begin
                if (rx_valid_i) begin
                    if (addr_ok) begin
                        addr_d = rx_data_i[ADDR_W-1:0];
                    end else begin
                        cmd_err_d = 1'b1;
                    end
                end
            end
            S_WR_DATA: begin
                if (rx_valid_i) begin
                    rf_addr_d   = addr_q;
                    rf_wrData_d = rx_data_i;
                    rf_wrEn_d   = 1'b1;
                end
            end
            S_RD_ADDR: begin
                if (rx_valid_i) begin
                    if (addr_ok) begin
                        addr_d    = rx_data_i[ADDR_W-1:0];
                        rf_addr_d = rx_data_i[ADDR_W-1:0];
                        rf_rdEn_d = 1'b1;
                        timer_d   = TMR_LOAD;
                    end else begin
                        cmd_err_d = 1'b1;
                    end
                end
            end
            S_RD_WAIT: begin
                if (rf_rdData_vld_i) begin
                    tx_data_d  = rf_rdData_i;
                    tx_valid_d = 1'b1;
                end else if (tmr_done) begin
                    cmd_err_d = 1'b1;
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end
            S_TX_HOLD: begin
                if (tx_accept) begin
                    tx_valid_d = 1'b0;
                end
            end
            default: begin
                tx_valid_d = 1'b0;
            end
        endcase
    end

    // Registered outputs and datapath; reset clears everything so no pulse survives
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            addr_q      <= '0;
            timer_q     <= '0;
            rf_addr_q   <= '0;
            rf_wrData_q <= '0;
            rf_wrEn_q   <= 1'b0;
            rf_rdEn_q   <= 1'b0;
            tx_data_q   <= '0;
            tx_valid_q  <= 1'b0;
            busy_q      <= 1'b0;
            cmd_err_q   <= 1'b0;
        end else begin
            addr_q      <= addr_d;
            timer_q     <= timer_d;
            rf_addr_q   <= rf_addr_d;
            rf_wrData_q <= rf_wrData_d;
            rf_wrEn_q   <= rf_wrEn_d;
            rf_rdEn_q   <= rf_rdEn_d;
            tx_data_q   <= tx_data_d;
            tx_valid_q  <= tx_valid_d;
            busy_q      <= busy_d;
            cmd_err_q   <= cmd_err_d;
        end
    end

    assign rf_addr_o   = rf_addr_q;
    assign rf_wrData_o = rf_wrData_q;
    assign rf_wrEn_o   = rf_wrEn_q;
    assign rf_rdEn_o   = rf_rdEn_q;
    assign tx_data_o   = tx_data_q;
    assign tx_valid_o  = tx_valid_q;
    assign busy_o      = busy_q;
    assign cmd_err_o   = cmd_err_q;

endmodule

// File: tb/tb_reg_ctrl.sv
// Testbench for reg_ctrl: a frame-level reference model checked every cycle,
// a small register-file responder, and directed frames with literal expectations.
module tb_reg_ctrl;

    localparam int RD_TIMEOUT = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic [3:0] rf_addr;
    logic [7:0] rf_wrData;
    logic       rf_wrEn;
    logic       rf_rdEn;
    logic [7:0] rf_rdData = 8'h00;
    logic       rf_rdData_vld = 1'b0;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready = 1'b0;
    logic       busy;
    logic       cmd_err;

    int checks = 0;
    int errors = 0;

    reg_ctrl #(
        .DATA_W(8), .ADDR_W(4), .CMD_WR(8'hAA), .CMD_RD(8'hBB), .RD_TIMEOUT(RD_TIMEOUT)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .rx_data_i(rx_data), .rx_valid_i(rx_valid),
        .rf_addr_o(rf_addr), .rf_wrData_o(rf_wrData),
        .rf_wrEn_o(rf_wrEn), .rf_rdEn_o(rf_rdEn),
        .rf_rdData_i(rf_rdData), .rf_rdData_vld_i(rf_rdData_vld),
        .tx_data_o(tx_data), .tx_valid_o(tx_valid), .tx_ready_i(tx_ready),
        .busy_o(busy), .cmd_err_o(cmd_err)
    );

    always #5 clk = ~clk;

    // Register file responder: one-cycle read latency, can be silenced
    logic [7:0] mem [16];
    logic       suppress = 1'b0;
    initial for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    always @(posedge clk) begin
        rf_rdData_vld <= rf_rdEn && !suppress;
        if (rf_rdEn) rf_rdData <= mem[rf_addr];
        if (rf_wrEn) mem[rf_addr] <= rf_wrData;
    end

    // Event monitors used by the directed checks
    int cyc = 0, n_wr = 0, n_rd = 0, n_err = 0, n_txv = 0, rd_cyc = 0, err_cyc = 0;
    logic [3:0] wr_addr = 4'h0, rd_addr = 4'h0;
    logic [7:0] wr_data = 8'h00;
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rf_wrEn) begin
            n_wr <= n_wr + 1; wr_addr <= rf_addr; wr_data <= rf_wrData;
        end
        if (rf_rdEn) begin
            n_rd <= n_rd + 1; rd_addr <= rf_addr; rd_cyc <= cyc;
        end
        if (cmd_err) begin
            n_err <= n_err + 1; err_cyc <= cyc;
        end
        if (tx_valid) n_txv <= n_txv + 1;
    end

    // Frame-level reference model: collects bytes of the current frame and
    // decides outputs when a frame completes or a read resolves.
    logic [7:0] fq[$];
    bit         waiting = 0, holding = 0;
    int         waited = 0;
    logic [3:0] e_addr = 0;
    logic [7:0] e_wrd = 0, e_txd = 0;
    logic       e_wr = 0, e_rd = 0, e_txv = 0, e_busy = 0, e_err = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fq.delete();
            waiting = 0; holding = 0; waited = 0;
            e_addr = 0; e_wrd = 0; e_txd = 0;
            e_wr = 0; e_rd = 0; e_txv = 0; e_busy = 0; e_err = 0;
        end else begin
            e_wr = 0; e_rd = 0; e_err = 0;
            if (holding) begin
                if (tx_ready) begin
                    e_txv = 0; holding = 0;
                end
            end else if (waiting) begin
                if (rf_rdData_vld) begin
                    e_txd = rf_rdData; e_txv = 1; holding = 1; waiting = 0;
                end else begin
                    waited++;
                    if (waited == RD_TIMEOUT) begin
                        e_err = 1; waiting = 0;
                    end
                end
            end else if (rx_valid) begin
                fq.push_back(rx_data);
                if (fq.size() == 1 && fq[0] != 8'hAA && fq[0] != 8'hBB) begin
                    e_err = 1; fq.delete();
                end else if (fq.size() == 2 && fq[1] > 8'h0F) begin
                    e_err = 1; fq.delete();
                end else if (fq.size() == 2 && fq[0] == 8'hBB) begin
                    e_rd = 1; e_addr = fq[1][3:0]; waiting = 1; waited = 0; fq.delete();
                end else if (fq.size() == 3) begin
                    e_wr = 1; e_addr = fq[1][3:0]; e_wrd = fq[2]; fq.delete();
                end
            end
            e_busy = (fq.size() != 0) || waiting || holding;
        end
    end

    // Cycle-by-cycle comparison of every output against the model
    always @(negedge clk) begin
        logic [24:0] act, exp;
        act = {rf_addr, rf_wrData, rf_wrEn, rf_rdEn, tx_data, tx_valid, busy, cmd_err};
        exp = {e_addr, e_wrd, e_wr, e_rd, e_txd, e_txv, e_busy, e_err};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL model_cycle t=%0t act=%h exp=%h (addr,wrd,wr,rd,txd,txv,busy,err)",
                     $time, act, exp);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data = b; rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_txv(input string name);
        for (int i = 0; i < 12 && !tx_valid; i++) @(negedge clk);
        chk(name, {31'd0, tx_valid}, 32'd1);
    endtask

    int b_wr, b_rd, b_err, b_txv;

    task automatic snap();
        b_wr = n_wr; b_rd = n_rd; b_err = n_err; b_txv = n_txv;
    endtask

    initial begin
        idle(3);
        chk("reset_outs", {7'd0, rf_addr, rf_wrData, rf_wrEn, rf_rdEn, tx_data, tx_valid, busy, cmd_err}, 32'd0);
        rst_n = 1'b1;
        idle(1);

        // 1: write reg5 = 0x0A
        snap();
        send_byte(8'hAA); send_byte(8'h05); send_byte(8'h0A);
        idle(2);
        chk("t1_wr_count", n_wr - b_wr, 1);
        chk("t1_wr_addr", wr_addr, 5);
        chk("t1_wr_data", wr_data, 8'h0A);
        chk("t1_busy", busy, 0);
        chk("t1_mem5", mem[5], 8'h0A);

        // 2: read reg5, hold tx for 3 cycles, then accept
        snap();
        send_byte(8'hBB); send_byte(8'h05);
        wait_txv("t2_txv_rise");
        chk("t2_rd_count", n_rd - b_rd, 1);
        chk("t2_rd_addr", rd_addr, 5);
        chk("t2_tx_data", tx_data, 8'h0A);
        for (int i = 0; i < 3; i++) begin
            idle(1);
            chk("t2_tx_hold", {tx_valid, tx_data}, {1'b1, 8'h0A});
        end
        tx_ready = 1'b1;
        idle(1);
        tx_ready = 1'b0;
        chk("t2_tx_drop", tx_valid, 0);
        chk("t2_busy", busy, 0);

        // 3: bad command byte, then write reg3 = 0x0F
        snap();
        send_byte(8'h37);
        idle(2);
        chk("t3_err_cycles", n_err - b_err, 1);
        chk("t3_no_access", (n_wr - b_wr) + (n_rd - b_rd), 0);
        send_byte(8'hAA); send_byte(8'h03); send_byte(8'h0F);
        idle(2);
        chk("t3_mem3", mem[3], 8'h0F);

        // 4: out-of-range address, then read reg3
        snap();
        send_byte(8'hAA); send_byte(8'h15);
        idle(2);
        chk("t4_err", n_err - b_err, 1);
        chk("t4_no_wr", n_wr - b_wr, 0);
        chk("t4_busy", busy, 0);
        send_byte(8'hBB); send_byte(8'h03);
        wait_txv("t4_txv_rise");
        chk("t4_tx_data", tx_data, 8'h0F);
        tx_ready = 1'b1;
        idle(1);
        tx_ready = 1'b0;

        // 5: read timeout with no rdData_vld
        suppress = 1'b1;
        snap();
        send_byte(8'hBB); send_byte(8'h02);
        for (int i = 0; i < 12 && n_err == b_err; i++) @(negedge clk);
        chk("t5_err", n_err - b_err, 1);
        chk("t5_rd_addr", rd_addr, 2);
        chk("t5_err_delay", err_cyc - rd_cyc, RD_TIMEOUT);
        idle(2);
        chk("t5_no_txv", n_txv - b_txv, 0);
        chk("t5_busy", busy, 0);
        suppress = 1'b0;

        // 6: reset between address and data byte
        snap();
        send_byte(8'hAA); send_byte(8'h05);
        #2 rst_n = 1'b0;
        idle(1);
        chk("t6_rst_outs", {7'd0, rf_addr, rf_wrData, rf_wrEn, rf_rdEn, tx_data, tx_valid, busy, cmd_err}, 32'd0);
        rst_n = 1'b1;
        idle(1);
        send_byte(8'h22);
        idle(2);
        chk("t6_err", n_err - b_err, 1);
        chk("t6_no_wr", n_wr - b_wr, 0);
        chk("t6_mem5", mem[5], 8'h0A);

        // Command byte as payload, and highest address
        send_byte(8'hAA); send_byte(8'h07); send_byte(8'hAA);
        send_byte(8'hAA); send_byte(8'h0F); send_byte(8'h55);
        idle(2);
        chk("pl_mem7", mem[7], 8'hAA);
        chk("max_memF", mem[15], 8'h55);

        // Bytes arriving during TX_HOLD are dropped
        snap();
        send_byte(8'hBB); send_byte(8'h0F);
        wait_txv("drop_txv_rise");
        chk("drop_tx_data", tx_data, 8'h55);
        send_byte(8'hAA);
        tx_ready = 1'b1;
        idle(1);
        tx_ready = 1'b0;
        send_byte(8'hAA); send_byte(8'h01); send_byte(8'h11);
        idle(2);
        chk("drop_mem1", mem[1], 8'h11);
        chk("drop_no_err", n_err - b_err, 0);

        idle(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
